// File: rtl/uart_rx_monitor.sv
// UART 8N1 receive monitor: synchronizer, mid-bit sampling FSM, FWFT byte FIFO, sticky error flags.
// Optional parity stage (8E1-style check) is compiled in with `define UART_MON_PARITY_EN.
//
// state    | meaning
// IDLE     | line idle, waiting for a falling edge on rxs
// START    | half-bit wait, confirm start bit is still low
// DATA     | sample 8 data bits, LSB first
// PARITY   | sample parity bit (UART_MON_PARITY_EN only)
// STOP     | sample stop bit, push byte or flag framing error
// BREAK    | line held low after a bad stop bit, wait for release
module uart_rx_monitor #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_i,
    output logic [7:0]                    dout_o,
    output logic                          dout_valid_o,
    input  logic                          dout_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
    output logic                          busy_o,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    output logic                          parity_err_o,
    input  logic                          clr_i
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] C_RELOAD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] C_HALF   = CW'(BAUD_DIV / 2 - 1);
    localparam logic [AW:0]   C_FULL   = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_MON_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_frame_err;
    logic          r_overflow;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_rxs;
    logic w_fall;
    logic w_tick;
    logic w_push;
    logic w_ferr_set;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_wr_en;
    logic w_ovf_set;

    assign w_rxs      = r_sync2;
    assign w_fall     = r_prev & ~w_rxs;
    assign w_tick     = (r_cnt == '0);
    assign w_push     = (r_state == S_STOP) && w_tick && w_rxs;
    assign w_ferr_set = (r_state == S_STOP) && w_tick && !w_rxs;

    assign w_full    = (r_count == C_FULL);
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && dout_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr_en   = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_fall) begin
                r_cnt <= C_HALF;
            end
        end else if (r_state != S_BREAK) begin
            r_cnt <= w_tick ? C_RELOAD : r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (!w_rxs) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift[r_bit_idx] <= w_rxs;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_MON_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_MON_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        r_state <= w_rxs ? S_IDLE : S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Set takes priority over a coincident clear so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= w_ferr_set | (r_frame_err & ~clr_i);
            r_overflow  <= w_ovf_set  | (r_overflow  & ~clr_i);
        end
    end

`ifdef UART_MON_PARITY_EN
    logic r_parity_err;
    logic w_perr_set;

    assign w_perr_set = (r_state == S_PARITY) && w_tick && (^{r_shift, w_rxs});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_perr_set | (r_parity_err & ~clr_i);
        end
    end

    assign parity_err_o = r_parity_err;
`else
    assign parity_err_o = 1'b0;
`endif

    assign dout_o       = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign dout_valid_o = !w_empty;
    assign fifo_cnt_o   = r_count;
    assign busy_o       = (r_state != S_IDLE);
    assign frame_err_o  = r_frame_err;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor: directed scenarios plus random frames, checked against a queue-based model.
module tb_uart_rx_monitor;

    localparam int BAUD  = 8;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       clr = 1'b0;
    logic       ready_fixed = 1'b1;
    logic       rand_mode = 1'b0;
    logic       rnd_ready = 1'b1;
    logic       dout_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic [4:0] fifo_cnt;
    logic       busy;
    logic       ferr;
    logic       ovf;
    logic       perr;

    assign dout_ready = rand_mode ? rnd_ready : ready_fixed;

    uart_rx_monitor #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_ready_i (dout_ready),
        .fifo_cnt_o   (fifo_cnt),
        .busy_o       (busy),
        .frame_err_o  (ferr),
        .overflow_o   (ovf),
        .parity_err_o (perr),
        .clr_i        (clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation side: every accepted byte is logged, checked later against the model queue.
    logic [7:0] obs [0:1023];
    int   n_pops = 0;
    int   n_valid = 0;
    int   n_busy_rise = 0;
    int   n_busy_cyc = 0;
    int   last_pop_cyc = 0;
    logic busy_d = 1'b0;

    always @(negedge clk) begin
        if (dout_valid) n_valid <= n_valid + 1;
        if (dout_valid && dout_ready) begin
            obs[n_pops] <= dout;
            n_pops <= n_pops + 1;
            last_pop_cyc <= cyc;
        end
        if (busy && !busy_d) n_busy_rise <= n_busy_rise + 1;
        if (busy) n_busy_cyc <= n_busy_cyc + 1;
        busy_d <= busy;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) rnd_ready = 1'($urandom % 2);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_q [$];
    logic exp_ferr = 1'b0;
    logic exp_ovf  = 1'b0;
    logic exp_perr = 1'b0;
    int   rd = 0;

    task automatic compare_pops();
        while (rd < n_pops) begin
            check_val("pop_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_val("pop_data", 32'(obs[rd]), 32'(exp_q.pop_front()));
            rd++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        idle(BAUD);
    endtask

    // Model: a good frame appends its byte unless DEPTH bytes are already pending.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit, input bit model);
        compare_pops();
        if (model) begin
            if (stop_bit) begin
                if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
                else exp_q.push_back(b);
            end else begin
                exp_ferr = 1'b1;
            end
`ifdef UART_MON_PARITY_EN
            if (^{b, par_bit}) exp_perr = 1'b1;
`endif
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_MON_PARITY_EN
        drive_bit(par_bit);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic check_flags(input string tag);
        check_val({tag, "_ferr"}, 32'(ferr), 32'(exp_ferr));
        check_val({tag, "_ovf"},  32'(ovf),  32'(exp_ovf));
        check_val({tag, "_perr"}, 32'(perr), 32'(exp_perr));
    endtask

    initial begin
        int t0;
        int v0;
        int b0;
        int p0;
        int lat;
        int gap;
        logic [7:0] b;
        logic pb;
        logic stop;
        logic busy44;

        rst = 1'b1;
        idle(4);
        check_val("rst_dout",  32'(dout), 32'd0);
        check_val("rst_valid", 32'(dout_valid), 32'd0);
        check_val("rst_cnt",   32'(fifo_cnt), 32'd0);
        check_val("rst_busy",  32'(busy), 32'd0);
        check_flags("rst");
        rst = 1'b0;
        idle(4);

        // single 0x55 frame: latency and one-cycle valid pulse
        v0 = n_valid;
        t0 = cyc;
        b = 8'h55;
        send_frame(b, 1'b1, ^b, 1);
        idle(BAUD);
        compare_pops();
        lat = last_pop_cyc - t0;
        check_val("t1_latency_ok", 32'(lat >= 75 && lat <= 81), 32'd1);
        check_val("t1_valid_cycles", n_valid - v0, 32'd1);
        check_flags("t1");

        // 2-cycle glitch on an idle line
        b0 = n_busy_cyc;
        p0 = n_pops;
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(20);
        check_val("t2_busy_len_ok", 32'((n_busy_cyc - b0) >= 1 && (n_busy_cyc - b0) <= 6), 32'd1);
        check_val("t2_busy_now", 32'(busy), 32'd0);
        check_val("t2_cnt", 32'(fifo_cnt), 32'd0);
        check_val("t2_no_pop", n_pops - p0, 32'd0);
        check_flags("t2");

        // bad stop bit, line held low, then recovery
        b0 = n_busy_rise;
        b = 8'hA3;
        send_frame(b, 1'b0, ^b, 1);
        check_val("t3_ferr_set", 32'(ferr), 32'(exp_ferr));
        idle(40);
        check_val("t3_busy_hold", 32'(busy), 32'd1);
        check_val("t3_one_frame", n_busy_rise - b0, 32'd1);
        check_val("t3_cnt", 32'(fifo_cnt), 32'd0);
        rx = 1'b1;
        idle(3 * BAUD);
        check_val("t3_idle", 32'(busy), 32'd0);
        b = 8'h12;
        send_frame(b, 1'b1, ^b, 1);
        idle(2 * BAUD);
        compare_pops();
        check_val("t3_q_empty", exp_q.size(), 32'd0);
        check_flags("t3_after");
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        exp_ferr = 1'b0;
        check_flags("t3_clr");

        // overflow: 17 bytes into a 16-entry FIFO with no consumer
        ready_fixed = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, ^b, 1);
        end
        idle(2 * BAUD);
        check_val("t4_cnt", 32'(fifo_cnt), exp_q.size());
        check_val("t4_head", 32'(dout), 32'(exp_q[0]));
        check_val("t4_valid", 32'(dout_valid), 32'd1);
        check_flags("t4_full");
        ready_fixed = 1'b1;
        idle(24);
        compare_pops();
        check_val("t4_drained", exp_q.size(), 32'd0);
        check_val("t4_cnt_after", 32'(fifo_cnt), 32'd0);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        exp_ovf = 1'b0;
        check_flags("t4_clr");

        // reset in the middle of bit 4 with one byte already buffered
        ready_fixed = 1'b0;
        b = 8'h99;
        send_frame(b, 1'b1, ^b, 1);
        idle(BAUD);
        check_val("t5_cnt_before", 32'(fifo_cnt), exp_q.size());
        b = 8'h3C;
        busy44 = 1'b0;
        fork
            send_frame(b, 1'b1, ^b, 0);
            begin
                idle(44);
                busy44 = busy;
                rst = 1'b1;
                exp_q.delete();
                exp_ferr = 1'b0;
                exp_ovf = 1'b0;
                exp_perr = 1'b0;
            end
        join
        check_val("t5_busy_mid", 32'(busy44), 32'd1);
        check_val("t5_busy_rst", 32'(busy), 32'd0);
        check_val("t5_cnt_rst", 32'(fifo_cnt), 32'd0);
        check_val("t5_valid_rst", 32'(dout_valid), 32'd0);
        rst = 1'b0;
        ready_fixed = 1'b1;
        idle(4);
        send_frame(b, 1'b1, ^b, 1);
        idle(2 * BAUD);
        compare_pops();
        check_val("t5_q_empty", exp_q.size(), 32'd0);
        check_flags("t5");

`ifdef UART_MON_PARITY_EN
        b = 8'h07;
        send_frame(b, 1'b1, 1'b0, 1);
        idle(2 * BAUD);
        compare_pops();
        check_val("t6_q_empty", exp_q.size(), 32'd0);
        check_flags("t6_bad");
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        exp_perr = 1'b0;
        send_frame(b, 1'b1, 1'b1, 1);
        idle(2 * BAUD);
        compare_pops();
        check_flags("t6_good");
`endif

        // random frames with random consumer backpressure
        rand_mode = 1'b1;
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            stop = 1'(($urandom % 6) != 0);
            pb = ^b;
`ifdef UART_MON_PARITY_EN
            if (($urandom % 4) == 0) pb = ~pb;
`endif
            send_frame(b, stop, pb, 1);
            gap = stop ? int'($urandom % 20) : BAUD + int'($urandom % 20);
            rx = 1'b1;
            idle(gap + 1);
        end
        rand_mode = 1'b0;
        idle(2 * BAUD);
        compare_pops();
        check_val("rand_q_empty", exp_q.size(), 32'd0);
        check_val("rand_cnt", 32'(fifo_cnt), 32'd0);
        check_flags("rand");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
